// File: rtl/id_stage_pkg.sv
// rtl/id_stage_pkg.sv - shared ALU op codes, RV32I opcodes, payload type and immediate helpers
package id_stage_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_EQ   = 4'd10,
    ALU_NEQ  = 4'd11,
    ALU_GE   = 4'd12,
    ALU_GEU  = 4'd13
  } alu_op_t;

  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    alu_op_t     alu_op;
    logic [31:0] data_1;
    logic [31:0] data_2;
    logic [4:0]  shamt;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        rd_we;
    logic [2:0]  funct3;
    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
    logic        is_load;
    logic        is_store;
    logic        is_system;
    logic        illegal;
  } payload_t;

  function automatic logic [31:0] imm_i(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:25], instr[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] instr);
    return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] instr);
    return {instr[31:12], 12'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] instr);
    return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/id_stage_decode.sv
// rtl/id_stage_decode.sv - combinational RV32I decoder producing the next execute payload
module id_stage_decode
  import id_stage_pkg::*;
(
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_rs1_data,
  input  logic [31:0] i_rs2_data,
  output payload_t    o_payload
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;

  assign opcode = i_instr[6:0];
  assign f3     = i_instr[14:12];
  assign f7     = i_instr[31:25];

  // Decode by opcode, then squash everything to a harmless ADD 0+0 if undecodable
  always_comb begin
    logic ill;
    ill       = 1'b0;
    o_payload = '0;
    o_payload.alu_op = ALU_ADD;
    o_payload.pc     = i_pc;
    o_payload.rd     = i_instr[11:7];
    o_payload.funct3 = f3;

    unique case (opcode)
      OPC_OP: begin
        o_payload.data_1 = i_rs1_data;
        o_payload.data_2 = i_rs2_data;
        o_payload.shamt  = i_rs2_data[4:0];
        o_payload.rd_we  = 1'b1;
        if (f7 == F7_BASE) begin
          unique case (f3)
            3'b000: o_payload.alu_op = ALU_ADD;
            3'b001: o_payload.alu_op = ALU_SLL;
            3'b010: o_payload.alu_op = ALU_SLT;
            3'b011: o_payload.alu_op = ALU_SLTU;
            3'b100: o_payload.alu_op = ALU_XOR;
            3'b101: o_payload.alu_op = ALU_SRL;
            3'b110: o_payload.alu_op = ALU_OR;
            3'b111: o_payload.alu_op = ALU_AND;
          endcase
        end else if (f7 == F7_ALT && f3 == 3'b000) begin
          o_payload.alu_op = ALU_SUB;
        end else if (f7 == F7_ALT && f3 == 3'b101) begin
          o_payload.alu_op = ALU_SRA;
        end else begin
          ill = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        o_payload.data_1 = i_rs1_data;
        o_payload.data_2 = imm_i(i_instr);
        o_payload.imm    = imm_i(i_instr);
        o_payload.rd_we  = 1'b1;
        unique case (f3)
          3'b000: o_payload.alu_op = ALU_ADD;
          3'b010: o_payload.alu_op = ALU_SLT;
          3'b011: o_payload.alu_op = ALU_SLTU;
          3'b100: o_payload.alu_op = ALU_XOR;
          3'b110: o_payload.alu_op = ALU_OR;
          3'b111: o_payload.alu_op = ALU_AND;
          3'b001: begin
            o_payload.alu_op = ALU_SLL;
            ill = (f7 != F7_BASE);
          end
          3'b101: begin
            o_payload.alu_op = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            ill = (f7 != F7_BASE) && (f7 != F7_ALT);
          end
        endcase
        // Immediate shifts carry the 5-bit shamt as operand 2 as well
        if (f3 == 3'b001 || f3 == 3'b101) begin
          o_payload.shamt  = i_instr[24:20];
          o_payload.data_2 = {27'b0, i_instr[24:20]};
        end
      end
      OPC_LUI: begin
        o_payload.data_2 = imm_u(i_instr);
        o_payload.imm    = imm_u(i_instr);
        o_payload.rd_we  = 1'b1;
      end
      OPC_AUIPC: begin
        o_payload.data_1 = i_pc;
        o_payload.data_2 = imm_u(i_instr);
        o_payload.imm    = imm_u(i_instr);
        o_payload.rd_we  = 1'b1;
      end
      OPC_JAL: begin
        o_payload.data_1 = i_pc;
        o_payload.data_2 = 32'd4;
        o_payload.imm    = imm_j(i_instr);
        o_payload.rd_we  = 1'b1;
        o_payload.is_jal = 1'b1;
      end
      OPC_JALR: begin
        o_payload.data_1  = i_pc;
        o_payload.data_2  = 32'd4;
        o_payload.imm     = imm_i(i_instr);
        o_payload.rd_we   = 1'b1;
        o_payload.is_jalr = 1'b1;
        ill = (f3 != 3'b000);
      end
      OPC_BRANCH: begin
        o_payload.data_1    = i_rs1_data;
        o_payload.data_2    = i_rs2_data;
        o_payload.imm       = imm_b(i_instr);
        o_payload.is_branch = 1'b1;
        unique case (f3)
          3'b000:  o_payload.alu_op = ALU_EQ;
          3'b001:  o_payload.alu_op = ALU_NEQ;
          3'b100:  o_payload.alu_op = ALU_SLT;
          3'b101:  o_payload.alu_op = ALU_GE;
          3'b110:  o_payload.alu_op = ALU_SLTU;
          3'b111:  o_payload.alu_op = ALU_GEU;
          default: ill = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        o_payload.data_1  = i_rs1_data;
        o_payload.data_2  = imm_i(i_instr);
        o_payload.imm     = imm_i(i_instr);
        o_payload.rd_we   = 1'b1;
        o_payload.is_load = 1'b1;
      end
      OPC_STORE: begin
        o_payload.data_1   = i_rs1_data;
        o_payload.data_2   = imm_s(i_instr);
        o_payload.imm      = imm_s(i_instr);
        o_payload.is_store = 1'b1;
      end
      OPC_MISC_MEM, OPC_SYSTEM: begin
        o_payload.is_system = 1'b1;
      end
      default: ill = 1'b1;
    endcase

    if (i_instr[1:0] != 2'b11) ill = 1'b1;

    if (ill) begin
      o_payload.alu_op    = ALU_ADD;
      o_payload.data_1    = '0;
      o_payload.data_2    = '0;
      o_payload.shamt     = '0;
      o_payload.imm       = '0;
      o_payload.rd_we     = 1'b0;
      o_payload.is_branch = 1'b0;
      o_payload.is_jal    = 1'b0;
      o_payload.is_jalr   = 1'b0;
      o_payload.is_load   = 1'b0;
      o_payload.is_store  = 1'b0;
      o_payload.is_system = 1'b0;
      o_payload.illegal   = 1'b1;
    end

    // x0 is never written
    if (o_payload.rd == 5'd0) o_payload.rd_we = 1'b0;
  end

endmodule

// File: rtl/id_stage.sv
// rtl/id_stage.sv - decode/issue stage: handshake pipeline register in front of execute
module id_stage
  import id_stage_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_pc,
  output logic [4:0]      o_rs1_addr,
  output logic [4:0]      o_rs2_addr,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output alu_op_t         o_alu_op,
  output logic [XLEN-1:0] o_data_1,
  output logic [XLEN-1:0] o_data_2,
  output logic [4:0]      o_shamt,
  output logic [XLEN-1:0] o_imm,
  output logic [XLEN-1:0] o_pc,
  output logic [4:0]      o_rd,
  output logic            o_rd_we,
  output logic [2:0]      o_funct3,
  output logic            o_is_branch,
  output logic            o_is_jal,
  output logic            o_is_jalr,
  output logic            o_is_load,
  output logic            o_is_store,
  output logic            o_is_system,
  output logic            o_illegal
);

  payload_t next_pl;
  payload_t pl;
  logic     valid_q;

  assign o_rs1_addr = i_instr[19:15];
  assign o_rs2_addr = i_instr[24:20];

  id_stage_decode u_decode (
    .i_instr    (i_instr),
    .i_pc       (i_pc),
    .i_rs1_data (i_rs1_data),
    .i_rs2_data (i_rs2_data),
    .o_payload  (next_pl)
  );

  // A flush drops the incoming word, so fetch may always hand it over
  assign o_ready = ~valid_q | i_ready | i_flush;

  // Pipeline register: reset beats flush, flush beats load; payload moves only on a load
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      pl      <= '0;
      pl.pc   <= RESET_PC;
    end else if (i_flush) begin
      valid_q <= 1'b0;
    end else if (i_valid && o_ready) begin
      valid_q <= 1'b1;
      pl      <= next_pl;
    end else if (i_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign o_valid     = valid_q;
  assign o_alu_op    = pl.alu_op;
  assign o_data_1    = pl.data_1;
  assign o_data_2    = pl.data_2;
  assign o_shamt     = pl.shamt;
  assign o_imm       = pl.imm;
  assign o_pc        = pl.pc;
  assign o_rd        = pl.rd;
  assign o_rd_we     = pl.rd_we;
  assign o_funct3    = pl.funct3;
  assign o_is_branch = pl.is_branch;
  assign o_is_jal    = pl.is_jal;
  assign o_is_jalr   = pl.is_jalr;
  assign o_is_load   = pl.is_load;
  assign o_is_store  = pl.is_store;
  assign o_is_system = pl.is_system;
  assign o_illegal   = pl.illegal;

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - self-checking bench for id_stage
module tb_id_stage;
  import id_stage_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0080;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, flush, out_valid, ex_ready;
  logic [31:0] instr, pc, rs1_data, rs2_data;
  logic [4:0]  rs1_addr, rs2_addr;
  alu_op_t     alu_op;
  logic [31:0] data_1, data_2, imm, out_pc;
  logic [4:0]  shamt, rd;
  logic        rd_we, is_branch, is_jal, is_jalr, is_load, is_store, is_system, illegal;
  logic [2:0]  funct3;

  id_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .o_ready(out_ready),
    .i_instr(instr), .i_pc(pc), .o_rs1_addr(rs1_addr), .o_rs2_addr(rs2_addr),
    .i_rs1_data(rs1_data), .i_rs2_data(rs2_data), .i_flush(flush),
    .o_valid(out_valid), .i_ready(ex_ready), .o_alu_op(alu_op),
    .o_data_1(data_1), .o_data_2(data_2), .o_shamt(shamt), .o_imm(imm),
    .o_pc(out_pc), .o_rd(rd), .o_rd_we(rd_we), .o_funct3(funct3),
    .o_is_branch(is_branch), .o_is_jal(is_jal), .o_is_jalr(is_jalr),
    .o_is_load(is_load), .o_is_store(is_store), .o_is_system(is_system),
    .o_illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr, pc, rs1, rs2;
    logic [3:0]  op;
    logic [31:0] d1, d2;
    logic [4:0]  sh;
    logic [31:0] im;
    logic        we;
    logic [5:0]  flags;  // {branch, jal, jalr, load, store, system}
    logic        ill;
  } vec_t;

  vec_t vecs[18];
  vec_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    instr = v.instr; pc = v.pc; rs1_data = v.rs1; rs2_data = v.rs2;
  endtask

  task automatic pop_check(input string tag);
    vec_t e;
    if (sb.size() == 0) begin
      chk({tag, " scoreboard empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    chk({tag, " valid"},  {31'b0, out_valid}, 32'd1);
    chk({tag, " op"},     {28'b0, alu_op}, {28'b0, e.op});
    chk({tag, " data_1"}, data_1, e.d1);
    chk({tag, " data_2"}, data_2, e.d2);
    chk({tag, " shamt"},  {27'b0, shamt}, {27'b0, e.sh});
    chk({tag, " imm"},    imm, e.im);
    chk({tag, " pc"},     out_pc, e.pc);
    chk({tag, " rd"},     {27'b0, rd}, {27'b0, e.instr[11:7]});
    chk({tag, " rd_we"},  {31'b0, rd_we}, {31'b0, e.we});
    chk({tag, " funct3"}, {29'b0, funct3}, {29'b0, e.instr[14:12]});
    chk({tag, " flags"},  {26'b0, is_branch, is_jal, is_jalr, is_load, is_store, is_system},
        {26'b0, e.flags});
    chk({tag, " illegal"}, {31'b0, illegal}, {31'b0, e.ill});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          instr          pc        rs1           rs2       op  d1            d2            sh   imm           we  flags      ill
    vecs[0]  = '{32'hFFD08293, 32'h100, 32'd10,        32'd3,    0,  32'd10,       32'hFFFFFFFD, 0,   32'hFFFFFFFD, 1, 6'b000000, 0};
    vecs[1]  = '{32'h402081B3, 32'h104, 32'd10,        32'd3,    1,  32'd10,       32'd3,        3,   32'd0,        1, 6'b000000, 0};
    vecs[2]  = '{32'h4030D213, 32'h108, 32'h80000000,  32'd3,    7,  32'h80000000, 32'd3,        3,   32'h403,      1, 6'b000000, 0};
    vecs[3]  = '{32'h00002063, 32'h10C, 32'd10,        32'd3,    0,  32'd0,        32'd0,        0,   32'd0,        0, 6'b000000, 1};
    vecs[4]  = '{32'h00208463, 32'h110, 32'd10,        32'd3,    10, 32'd10,       32'd3,        0,   32'd8,        0, 6'b100000, 0};
    vecs[5]  = '{32'hFE209EE3, 32'h114, 32'd10,        32'd3,    11, 32'd10,       32'd3,        0,   32'hFFFFFFFC, 0, 6'b100000, 0};
    vecs[6]  = '{32'h00100013, 32'h118, 32'd0,         32'd3,    0,  32'd0,        32'd1,        0,   32'd1,        0, 6'b000000, 0};
    vecs[7]  = '{32'h123453B7, 32'h11C, 32'd10,        32'd3,    0,  32'd0,        32'h12345000, 0,   32'h12345000, 1, 6'b000000, 0};
    vecs[8]  = '{32'hFFFFF417, 32'h120, 32'd10,        32'd3,    0,  32'h120,      32'hFFFFF000, 0,   32'hFFFFF000, 1, 6'b000000, 0};
    vecs[9]  = '{32'h010000EF, 32'h124, 32'd10,        32'd3,    0,  32'h124,      32'd4,        0,   32'd16,       1, 6'b010000, 0};
    vecs[10] = '{32'h008100E7, 32'h128, 32'd10,        32'd3,    0,  32'h128,      32'd4,        0,   32'd8,        1, 6'b001000, 0};
    vecs[11] = '{32'hFF80A303, 32'h12C, 32'h1000,      32'd3,    0,  32'h1000,     32'hFFFFFFF8, 0,   32'hFFFFFFF8, 1, 6'b000100, 0};
    vecs[12] = '{32'h0020A623, 32'h130, 32'h1000,      32'd3,    0,  32'h1000,     32'd12,       0,   32'd12,       0, 6'b000010, 0};
    vecs[13] = '{32'h00000073, 32'h134, 32'd10,        32'd3,    0,  32'd0,        32'd0,        0,   32'd0,        0, 6'b000001, 0};
    vecs[14] = '{32'h00100012, 32'h138, 32'd10,        32'd3,    0,  32'd0,        32'd0,        0,   32'd0,        0, 6'b000000, 1};
    vecs[15] = '{32'h022081B3, 32'h13C, 32'd10,        32'd3,    0,  32'd0,        32'd0,        0,   32'd0,        0, 6'b000000, 1};
    vecs[16] = '{32'h40309213, 32'h140, 32'd10,        32'd3,    0,  32'd0,        32'd0,        0,   32'd0,        0, 6'b000000, 1};
    vecs[17] = '{32'h0020B4B3, 32'h144, 32'd10,        32'h25,   4,  32'd10,       32'h25,       5,   32'd0,        1, 6'b000000, 0};

    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; ex_ready = 1'b1;
    instr = '0; pc = '0; rs1_data = '0; rs2_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset valid",   {31'b0, out_valid}, 32'd0);
    chk("reset pc",      out_pc, RST_PC);
    chk("reset op",      {28'b0, alu_op}, 32'd0);
    chk("reset data_2",  data_2, 32'd0);
    chk("reset illegal", {31'b0, illegal}, 32'd0);
    chk("reset ready",   {31'b0, out_ready}, 32'd1);

    // Back-to-back issue of every table entry with execute always ready
    foreach (vecs[i]) begin
      @(negedge clk);
      if (sb.size() > 0) pop_check($sformatf("vec%0d", i - 1));
      drive(vecs[i]);
      in_valid = 1'b1;
      sb.push_back(vecs[i]);
      #1;
      chk($sformatf("vec%0d rs1_addr", i), {27'b0, rs1_addr}, {27'b0, vecs[i].instr[19:15]});
      chk($sformatf("vec%0d rs2_addr", i), {27'b0, rs2_addr}, {27'b0, vecs[i].instr[24:20]});
    end
    @(negedge clk);
    pop_check("vec17");
    in_valid = 1'b0;
    @(negedge clk);
    chk("drain valid", {31'b0, out_valid}, 32'd0);

    // Stall three cycles, then release with the next instruction waiting
    ex_ready = 1'b0;
    drive(vecs[0]); in_valid = 1'b1; sb.push_back(vecs[0]);
    @(negedge clk);
    pop_check("stall load");
    drive(vecs[1]);
    repeat (3) begin
      @(negedge clk);
      chk("stall ready",  {31'b0, out_ready}, 32'd0);
      chk("stall valid",  {31'b0, out_valid}, 32'd1);
      chk("stall data_1", data_1, 32'd10);
      chk("stall data_2", data_2, 32'hFFFFFFFD);
      chk("stall op",     {28'b0, alu_op}, 32'd0);
      chk("stall pc",     out_pc, 32'h100);
    end
    ex_ready = 1'b1; sb.push_back(vecs[1]);
    @(negedge clk);
    pop_check("stall release");
    in_valid = 1'b0;
    @(negedge clk);

    // Flush while stalled with a new instruction offered
    ex_ready = 1'b0;
    drive(vecs[7]); in_valid = 1'b1; sb.push_back(vecs[7]);
    @(negedge clk);
    pop_check("flush load");
    drive(vecs[8]); flush = 1'b1;
    #1;
    chk("flush ready", {31'b0, out_ready}, 32'd1);
    @(negedge clk);
    chk("flush valid", {31'b0, out_valid}, 32'd0);
    flush = 1'b0; in_valid = 1'b0; ex_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("flushed gone", {31'b0, out_valid}, 32'd0);
    end

    // Reset during a stall discards the held payload
    ex_ready = 1'b0;
    drive(vecs[6]); in_valid = 1'b1; sb.push_back(vecs[6]);
    @(negedge clk);
    pop_check("x0 load");
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst hold valid", {31'b0, out_valid}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst valid",  {31'b0, out_valid}, 32'd0);
    chk("rst pc",     out_pc, RST_PC);
    chk("rst data_2", data_2, 32'd0);
    chk("rst imm",    imm, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Decode/issue stage of the RV32I core; it is the producer side of the ALU interface.
- Takes a fetched instruction plus register-file read data and produces a registered ALU op, both operands, shamt, immediate and control flags for the execute stage.
- Single pipeline register with valid/ready handshake on both sides, plus flush.

Parameters:
- XLEN, 32, datapath width (only 32 supported).
- RESET_PC, 0, value of o_pc after reset.

Ports:
- i_clk  in  1  core clock.
- i_rst  in  1  synchronous, active-high reset.
- i_valid  in  1  fetch has an instruction.
- o_ready  out  1  stage accepts the instruction this cycle.
- i_instr  in  32  instruction word.
- i_pc  in  XLEN  PC of i_instr.
- o_rs1_addr  out  5  combinational i_instr[19:15].
- o_rs2_addr  out  5  combinational i_instr[24:20].
- i_rs1_data  in  XLEN  regfile read data, same cycle as the address.
- i_rs2_data  in  XLEN  regfile read data, same cycle as the address.
- i_flush  in  1  kill the held and incoming instruction.
- o_valid  out  1  execute-side payload valid.
- i_ready  in  1  execute stage consumes the payload.
- o_alu_op  out  `ALUOPS  ALU operation.
- o_data_1  out  XLEN  ALU operand 1.
- o_data_2  out  XLEN  ALU operand 2.
- o_shamt  out  5  shift amount.
- o_imm  out  XLEN  sign-extended immediate (branch/jump/mem offset).
- o_pc  out  XLEN  PC of the issued instruction.
- o_rd  out  5  destination register.
- o_rd_we  out  1  writeback enable.
- o_funct3  out  3  raw funct3 for the memory and CSR units.
- o_is_branch, o_is_jal, o_is_jalr, o_is_load, o_is_store, o_is_system  out  1 each  class flags.
- o_illegal  out  1  undecodable instruction.

Behaviour:
- Reset: o_valid=0, o_pc=RESET_PC, every other output 0 (o_alu_op=`ADD=0).
- Handshake: o_ready = ~o_valid | i_ready. The stage loads when i_valid & o_ready; 1-cycle latency from acceptance to o_valid.
- Hold: while o_valid & ~i_ready, all outputs stay bit-stable and i_instr is not sampled.
- If o_valid & i_ready & ~i_valid, then o_valid=0 next cycle.
- Flush: i_flush forces o_valid=0 next cycle and overrides a simultaneous load. The incoming instruction is dropped, and o_ready still reads 1 so fetch drains.
- Reset beats flush and load; mid-stall reset discards the payload.
- Decode by opcode[6:0]:
  - OP 0110011: funct7 0000000 gives ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND by funct3. funct7 0100000 gives SUB (f3=000) or SRA (f3=101). Anything else is illegal. data_1=rs1, data_2=rs2, shamt=rs2[4:0].
  - OP-IMM 0010011:
    - data_1=rs1, data_2=imm_I.
    - SLLI needs funct7=0000000.
    - SRLI/SRAI need funct7 0000000/0100000.
    - shifts set shamt=instr[24:20] and data_2={27'b0,shamt}.
    - Other funct7 on shifts is illegal.
  - LUI: ADD, data_1=0, data_2=imm_U.
  - AUIPC: ADD, data_1=pc, data_2=imm_U.
  - JAL: ADD, data_1=pc, data_2=4, imm=imm_J, o_is_jal.
  - JALR: funct3 must be 000. ADD pc+4, imm=imm_I, o_is_jalr.
  - BRANCH: funct3 to op is 000 EQ, 001 NEQ, 100 SLT, 101 GE, 110 SLTU, 111 GEU; 010/011 are illegal. data_1=rs1, data_2=rs2, imm=imm_B, rd_we=0.
  - LOAD: ADD rs1+imm_I.
  - STORE: ADD rs1+imm_S, rd_we=0.
  - MISC-MEM/SYSTEM: o_is_system=1, ADD 0+0, rd_we=0. CSR work is done downstream.
  - Any other opcode, or instr[1:0]!=11, is illegal.
- Illegal: o_illegal=1, all class flags 0, rd_we=0, ADD 0+0. It is still issued with o_valid=1 for the trap logic.
- o_rd_we is forced 0 when rd==0.
- Immediates are sign-extended from instr[31]. imm_B and imm_J have bit0=0. imm_U = {instr[31:12],12'b0}.

Decomposition:
- header.vh holds XLEN, ALUOPS, the ALU op codes (ADD..GEU, 0..13), and the RV32I opcode constants.
- id_decode is a purely combinational sub-module: i_instr/pc/rs data in, next payload out.
- id_stage owns the handshake register and flush/reset logic.

Test Plan:
- addi x5,x1,-3 (0xFFD08293), rs1=10, i_ready=1 → next cycle: o_valid=1, op ADD, data_1=10, data_2=0xFFFFFFFD, rd=5, rd_we=1.
- sub x3,x1,x2 (0x402081B3), then srai x4,x1,3 (0x4030D213) → op SUB, then op SRA with shamt=3 and data_2=3.
- Branch with funct3=010 (0x00002063) → o_illegal=1, rd_we=0, o_is_branch=0. beq x1,x2 gives op EQ with the correct imm_B.
- Issue with i_ready=0 for 3 cycles → o_ready=0 and outputs unchanged. Raise i_ready with the next instruction on i_instr → new payload appears 1 cycle later.
- Assert i_flush with i_valid=1 while a payload is stalled → o_valid=0 next cycle and the flushed instr never appears.
- addi x0,x0,1 → rd_we=0. Assert i_rst mid-stall → o_valid=0 and o_pc=RESET_PC the next cycle.
